// File: rtl/loss_arbiter.sv
// Round-robin scheduler that shares one loss unit between NREQ requesters.
// A granted requester's model/num are muxed onto the loss unit. This block
// drives the unit's input_ready/output_taken handshake. The latched result
// is then returned to the owner over a valid/ready response channel.
module loss_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IL    = 4,
  parameter int unsigned FL    = 16,
  parameter int unsigned size  = 16,
  parameter int unsigned width = $clog2(size),
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0]               req_model,
  input  logic [NREQ-1:0][width-1:0]    req_num,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               rsp_valid,
  output logic signed [IL+FL-1:0]       rsp_loss,
  input  logic [NREQ-1:0]               rsp_ready,
  output logic [IDW-1:0]                sel,
  output logic                          lu_model,
  output logic [width-1:0]              lu_num,
  output logic                          lu_input_ready,
  output logic                          lu_output_taken,
  input  logic [1:0]                    lu_state,
  input  logic signed [IL+FL-1:0]       lu_out,
  output logic                          busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  localparam logic [1:0] LuIdle = 2'b00;
  localparam logic [1:0] LuDone = 2'b10;

  state_e                  state_q;
  logic [IDW-1:0]          last_q;
  logic signed [IL+FL-1:0] loss_q;

  logic                    gnt_found;
  logic [IDW-1:0]          gnt_idx;
  logic [IDW-1:0]          cand;

  // Round-robin pick: first valid requester scanning last+1, last+2, ... mod NREQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = IDW'((int'(last_q) + i) % int'(NREQ));
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Transaction FSM plus the operand-select, result and priority registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= IDW'(NREQ - 1);
      sel      <= '0;
      lu_model <= 1'b0;
      lu_num   <= '0;
      loss_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            sel      <= gnt_idx;
            lu_model <= req_model[gnt_idx];
            lu_num   <= req_num[gnt_idx];
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          // A withdrawn request wins over a ready loss unit; last stays put
          if (!req_valid[sel]) begin
            state_q <= StIdle;
          end else if (lu_state == LuIdle) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // Sample now: the unit clears as soon as it sees output_taken
          if (lu_state == LuDone) begin
            loss_q  <= lu_out;
            state_q <= StRespond;
          end
        end
        StRespond: begin
          if (rsp_ready[sel]) begin
            last_q  <= sel;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake strobes decoded from the current state and the unit's status
  always_comb begin
    req_ready       = '0;
    rsp_valid       = '0;
    lu_input_ready  = 1'b0;
    lu_output_taken = 1'b0;
    unique case (state_q)
      StIssue: begin
        lu_input_ready = 1'b1;
        if (req_valid[sel] && (lu_state == LuIdle)) begin
          req_ready[sel] = 1'b1;
        end
      end
      StWait: begin
        if (lu_state == LuDone) begin
          lu_output_taken = 1'b1;
        end
      end
      StRespond: rsp_valid[sel] = 1'b1;
      default: ;
    endcase
  end

  assign rsp_loss = loss_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_loss_arbiter.sv
// Scoreboard bench for loss_arbiter: directed stimulus pushes expected
// responses; a monitor pops and compares on every response handshake.
module tb_loss_arbiter;

  localparam int NREQ  = 4;
  localparam int IL    = 4;
  localparam int FL    = 16;
  localparam int SIZE  = 16;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;
  localparam int LW    = IL + FL;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_model;
  logic [NREQ-1:0][WIDTH-1:0]  req_num;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             rsp_valid;
  logic signed [LW-1:0]        rsp_loss;
  logic [NREQ-1:0]             rsp_ready;
  logic [IDW-1:0]              sel;
  logic                        lu_model;
  logic [WIDTH-1:0]            lu_num;
  logic                        lu_input_ready;
  logic                        lu_output_taken;
  logic [1:0]                  lu_state;
  logic signed [LW-1:0]        lu_out;
  logic                        busy;

  always #5 clk = ~clk;

  loss_arbiter #(
    .NREQ (NREQ),
    .IL   (IL),
    .FL   (FL),
    .size (SIZE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_model       (req_model),
    .req_num         (req_num),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_loss        (rsp_loss),
    .rsp_ready       (rsp_ready),
    .sel             (sel),
    .lu_model        (lu_model),
    .lu_num          (lu_num),
    .lu_input_ready  (lu_input_ready),
    .lu_output_taken (lu_output_taken),
    .lu_state        (lu_state),
    .lu_out          (lu_out),
    .busy            (busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int            idx;
    logic [LW-1:0] loss;
  } exp_t;
  exp_t sb[$];

  // Loss-unit stub: idle -> busy (busy_len+1 cycles) -> done -> idle on taken
  logic [LW-1:0] loss_tab [NREQ];
  logic [1:0]    st_q;
  logic [1:0]    man_state;
  logic          stub_auto;
  int            busy_len;
  int            bcnt;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      st_q <= 2'b00;
      bcnt <= 0;
    end else if (stub_auto) begin
      case (st_q)
        2'b00: if (lu_input_ready) begin st_q <= 2'b01; bcnt <= 0; end
        2'b01: if (bcnt >= busy_len) st_q <= 2'b10; else bcnt <= bcnt + 1;
        2'b10: if (lu_output_taken) st_q <= 2'b00;
        default: st_q <= 2'b00;
      endcase
    end
  end

  assign lu_state = stub_auto ? st_q : man_state;
  assign lu_out   = loss_tab[sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int g);
    exp_t e;
    e.idx  = g;
    e.loss = loss_tab[g];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for the accept pulse of requester g, then withdraw its request
  task automatic wait_grant(input int g);
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check($sformatf("grant_%0d", g), 32'(req_ready), 32'(1 << g));
    @(negedge clk);
    req_valid[g] = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 40; w++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_lu_model"}, 32'(lu_model), 32'd0);
    check({tag, "_lu_num"}, 32'(lu_num), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_loss"}, 32'($unsigned(rsp_loss)), 32'd0);
    check({tag, "_input_ready"}, 32'(lu_input_ready), 32'd0);
    check({tag, "_output_taken"}, 32'(lu_output_taken), 32'd0);
  endtask

  // Response monitor: inputs settle at the falling edge, sample a bit later
  always begin
    @(negedge clk);
    #3;
    if (!reset && ((rsp_valid & rsp_ready) != '0)) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_idx", 32'(rsp_valid), 32'(1 << e.idx));
        check("rsp_loss", 32'($unsigned(rsp_loss)), 32'(e.loss));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    int prev;
    order = '{0, 1, 2, 3, 0};
    prev  = 0;
    reset = 1'b1;
    req_valid = '0;
    req_model = '0;
    req_num   = '0;
    rsp_ready = '0;
    stub_auto = 1'b1;
    man_state = 2'b00;
    busy_len  = 0;
    loss_tab[0] = 20'h1_1111;
    loss_tab[1] = 20'h2_2222;
    loss_tab[2] = 20'h0_8000;
    loss_tab[3] = 20'hF_F000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Single request with cycle-exact latency
    req_model  = 4'b0100;
    req_num[2] = 4'd5;
    rsp_ready  = 4'b1111;
    req_valid  = 4'b0100;
    push(2);
    @(negedge clk);
    check("c1_req_ready", 32'(req_ready), 32'h4);
    check("c1_input_ready", 32'(lu_input_ready), 32'd1);
    check("c1_sel", 32'(sel), 32'd2);
    check("c1_lu_model", 32'(lu_model), 32'd1);
    check("c1_lu_num", 32'(lu_num), 32'd5);
    @(negedge clk);
    check("c2_req_ready", 32'(req_ready), 32'd0);
    check("c2_input_ready", 32'(lu_input_ready), 32'd0);
    check("c2_output_taken", 32'(lu_output_taken), 32'd0);
    req_valid = '0;
    @(negedge clk);
    check("c3_output_taken", 32'(lu_output_taken), 32'd1);
    check("c3_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("c4_rsp_valid", 32'(rsp_valid), 32'h4);
    check("c4_rsp_loss", 32'($unsigned(rsp_loss)), 32'h0_8000);
    check("c4_output_taken", 32'(lu_output_taken), 32'd0);
    @(negedge clk);
    check("c5_idle", 32'(busy), 32'd0);

    // All requesters held valid: fair order 0,1,2,3,0 at one grant per 5 cycles
    do_reset();
    req_model = '0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) push(order[k]);
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 12; w++) begin
        @(negedge clk);
        if (req_ready != '0) break;
      end
      check($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(1 << order[k]));
      if (k > 0) check("rr_spacing", 32'(cyc - prev), 32'd5);
      prev = cyc;
    end
    @(negedge clk);
    req_valid = '0;
    drain();

    // Response back-pressure: result held, no new grant while stalled
    rsp_ready = '0;
    req_valid = 4'b0010;
    push(1);
    wait_grant(1);
    for (int w = 0; w < 10; w++) begin
      if (rsp_valid != '0) break;
      @(negedge clk);
    end
    req_valid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      check("bp_rsp_loss", 32'($unsigned(rsp_loss)), 32'(loss_tab[1]));
      check("bp_input_ready", 32'(lu_input_ready), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    check("bp_release_idle", 32'(busy), 32'd0);
    check("bp_release_rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = 4'b1111;
    push(3);
    wait_grant(3);
    drain();

    // Long-running loss unit: 20 busy cycles before done
    busy_len  = 19;
    req_valid = 4'b0001;
    push(0);
    wait_grant(0);
    check("slow_taken_0", 32'(lu_output_taken), 32'd0);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      check("slow_taken_low", 32'(lu_output_taken), 32'd0);
      check("slow_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("slow_taken_pulse", 32'(lu_output_taken), 32'd1);
    @(negedge clk);
    check("slow_taken_end", 32'(lu_output_taken), 32'd0);
    check("slow_rsp_valid", 32'(rsp_valid), 32'h1);
    busy_len = 0;
    drain();

    // Withdrawn request during ISSUE: abort, no accept, same requester next
    stub_auto = 1'b0;
    man_state = 2'b10;
    req_valid = 4'b0010;
    @(negedge clk);
    check("ab_input_ready", 32'(lu_input_ready), 32'd1);
    check("ab_req_ready", 32'(req_ready), 32'd0);
    check("ab_sel", 32'(sel), 32'd1);
    @(negedge clk);
    check("ab_hold_issue", 32'(lu_input_ready), 32'd1);
    check("ab_hold_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_idle_req_ready", 32'(req_ready), 32'd0);
    check("ab_idle_input_ready", 32'(lu_input_ready), 32'd0);
    stub_auto = 1'b1;
    req_valid = 4'b0110;
    push(1);
    wait_grant(1);
    req_valid[2] = 1'b0;
    drain();

    // Reset during WAIT drops the transaction; requester 0 then leads again
    busy_len  = 5;
    req_valid = 4'b0100;
    wait_grant(2);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    reset     = 1'b0;
    busy_len  = 0;
    req_valid = 4'b1001;
    push(0);
    push(3);
    wait_grant(0);
    wait_grant(3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
